// File: rtl/sha256_msg_sequencer.sv
`timescale 1ns/1ps
// sha256_msg_sequencer: FIPS 180-4 message padding and 512-bit chunk sequencing for an iterative SHA-256 core
// Ports:
//   clk, rst                                 clock, asynchronous active-low reset
//   s_data, s_nbytes, s_last, s_valid/ready  big-endian message word stream (first byte in [31:24])
//   core_chunk, core_hash_in, core_chunk_flag chunk and chaining value issued to the core
//   core_hash_out, core_hash_valid           core result
//   digest, digest_valid, busy               final digest and status
// Optional build macro SHA256_IV_LOAD_EN adds iv_in, iv_load, len_init for midstate resume.
module sha256_msg_sequencer #(
    parameter int LEN_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      s_data,
    input  logic [2:0]       s_nbytes,
    input  logic             s_last,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [511:0]     core_chunk,
    output logic [255:0]     core_hash_in,
    output logic             core_chunk_flag,
    input  logic [255:0]     core_hash_out,
    input  logic             core_hash_valid,
`ifdef SHA256_IV_LOAD_EN
    input  logic [255:0]     iv_in,
    input  logic             iv_load,
    input  logic [LEN_W-1:0] len_init,
`endif
    output logic [255:0]     digest,
    output logic             digest_valid,
    output logic             busy
);
    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, PAD, DONE} state_t;

    state_t          state;
    logic [31:0]     w [16];
    logic [31:0]     last_w [16];
    logic [3:0]      idx;
    logic [LEN_W-1:0] len, len_base, len_next;
    logic [255:0]    chain;
    logic            final_chunk, pad_pend, pad_80;
    logic            accept;
    logic [2:0]      nb;
    logic [4:0]      used;
    logic            short_tail;
    logic [31:0]     tail;
    logic [63:0]     len64, len_next64;

    assign accept = s_valid & s_ready;
    // Only a final word may carry fewer than four bytes; anything else counts as a full word.
    assign nb = (s_last && s_nbytes <= 3'd4) ? s_nbytes : 3'd4;
`ifdef SHA256_IV_LOAD_EN
    logic iv_take;
    assign iv_take  = iv_load && (state == IDLE || state == FILL) && idx == 4'd0 && len == '0;
    assign len_base = iv_take ? len_init : len;
`else
    assign len_base = len;
`endif
    assign len_next   = len_base + LEN_W'({nb, 3'b000});
    assign len64      = 64'(len);
    assign len_next64 = 64'(len_next);
    // Keep the valid bytes and place the 0x80 marker right after them; nb==4 shifts it out entirely.
    assign tail = (s_data & ~(32'hffff_ffff >> {nb, 3'b000})) | (32'h8000_0000 >> {nb, 3'b000});
    // Words consumed by data plus the 0x80 marker; the length needs words 14..15 free.
    assign used       = 5'(idx) + (nb == 3'd4 ? 5'd2 : 5'd1);
    assign short_tail = used <= 5'd14;

    always_comb begin
        for (int j = 0; j < 16; j++) begin
            last_w[j] = 4'(j) < idx ? w[j] :
                        4'(j) == idx ? tail :
                        (5'(j) == 5'(idx) + 5'd1 && nb == 3'd4) ? 32'h8000_0000 :
                        (short_tail && j == 14) ? len_next64[63:32] :
                        (short_tail && j == 15) ? len_next64[31:0] : 32'h0;
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_chunk
        assign core_chunk[511-32*g -: 32] = w[g];
    end
    assign core_hash_in = chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            idx             <= '0;
            len             <= '0;
            chain           <= IV;
            s_ready         <= 1'b0;
            core_chunk_flag <= 1'b0;
            digest          <= '0;
            digest_valid    <= 1'b0;
            busy            <= 1'b0;
            final_chunk     <= 1'b0;
            pad_pend        <= 1'b0;
            pad_80          <= 1'b0;
            for (int j = 0; j < 16; j++) w[j] <= '0;
        end else begin
            digest_valid <= 1'b0;
`ifdef SHA256_IV_LOAD_EN
            if (iv_take) begin
                chain <= iv_in;
                len   <= len_init;
            end
`endif
            case (state)
                IDLE: begin
                    s_ready <= 1'b1;
                    state   <= FILL;
                end
                FILL: if (accept) begin
                    busy <= 1'b1;
                    len  <= len_next;
                    if (s_last) begin
                        w               <= last_w;
                        idx             <= '0;
                        s_ready         <= 1'b0;
                        core_chunk_flag <= 1'b1;
                        final_chunk     <= short_tail;
                        pad_pend        <= !short_tail;
                        // Full last word in slot 15: the marker did not fit and opens the pad chunk.
                        pad_80          <= nb == 3'd4 && idx == 4'd15;
                        state           <= ISSUE;
                    end else begin
                        w[idx] <= s_data;
                        idx    <= idx + 4'd1;
                        if (idx == 4'd15) begin
                            s_ready         <= 1'b0;
                            core_chunk_flag <= 1'b1;
                            final_chunk     <= 1'b0;
                            pad_pend        <= 1'b0;
                            state           <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    core_chunk_flag <= 1'b0;
                    state           <= WAIT;
                end
                // Chunk and chaining value stay frozen here because the core reads hash_in combinationally.
                WAIT: if (core_hash_valid) begin
                    chain   <= core_hash_out;
                    s_ready <= !final_chunk && !pad_pend;
                    state   <= final_chunk ? DONE : pad_pend ? PAD : FILL;
                end
                PAD: begin
                    for (int j = 0; j < 16; j++)
                        w[j] <= (j == 0 && pad_80) ? 32'h8000_0000 :
                                j == 14 ? len64[63:32] :
                                j == 15 ? len64[31:0] : 32'h0;
                    pad_pend        <= 1'b0;
                    final_chunk     <= 1'b1;
                    core_chunk_flag <= 1'b1;
                    state           <= ISSUE;
                end
                DONE: begin
                    digest       <= chain;
                    digest_valid <= 1'b1;
                    chain        <= IV;
                    len          <= '0;
                    idx          <= '0;
                    busy         <= 1'b0;
                    s_ready      <= 1'b1;
                    state        <= FILL;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_msg_sequencer.sv
`timescale 1ns/1ps
// tb_sha256_msg_sequencer: directed message vectors against a behavioural SHA-256 core with 65-cycle latency
module tb_sha256_msg_sequencer;
    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [2047:0] KT = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  s_data = '0;
    logic [2:0]   s_nbytes = '0;
    logic         s_last = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [511:0] core_chunk;
    logic [255:0] core_hash_in;
    logic         core_chunk_flag;
    logic [255:0] core_hash_out;
    logic         core_hash_valid;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;

    always #5 clk = ~clk;

    sha256_msg_sequencer dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_nbytes(s_nbytes), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .core_chunk(core_chunk), .core_hash_in(core_hash_in), .core_chunk_flag(core_chunk_flag),
        .core_hash_out(core_hash_out), .core_hash_valid(core_hash_valid),
        .digest(digest), .digest_valid(digest_valid), .busy(busy)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] m [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        for (int i = 0; i < 16; i++) m[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            m[i] = (rotr(m[i-2], 17) ^ rotr(m[i-2], 19) ^ (m[i-2] >> 10)) + m[i-7] +
                   (rotr(m[i-15], 7) ^ rotr(m[i-15], 18) ^ (m[i-15] >> 3)) + m[i-16];
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KT[2047-32*i -: 32] + m[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + h[255:224], b + h[223:192], c + h[191:160], d + h[159:128],
                e + h[127:96], f + h[95:64], g + h[63:32], hh + h[31:0]};
    endfunction

    // Core model: result valid exactly 65 cycles after the load strobe; a new strobe restarts it.
    logic [255:0] res = '0, hin_f = '0;
    logic [511:0] chk_f = '0;
    int           cnt = 0;
    bit           run = 1'b0;
    int           nflags = 0;
    bit           stray = 1'b0;
    logic         core_vld;
    assign core_vld        = run && cnt == 65;
    assign core_hash_valid = core_vld || stray;
    assign core_hash_out   = core_vld ? res : {8{32'hdeadbeef}};

    always @(posedge clk) begin
        if (core_chunk_flag) begin
            run    <= 1'b1;
            cnt    <= 1;
            res    <= sha_compress(core_hash_in, core_chunk);
            hin_f  <= core_hash_in;
            chk_f  <= core_chunk;
            nflags <= nflags + 1;
        end else if (run) begin
            if (cnt == 65) run <= 1'b0;
            else cnt <= cnt + 1;
        end
    end

    int nvec = 0, nerr = 0, dv_cnt = 0;
    bit prev_flag = 1'b0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (digest_valid) dv_cnt++;
        if (core_chunk_flag) check("flag_one_cycle", 512'(prev_flag), 512'(0));
        prev_flag = core_chunk_flag;
        if (core_vld) begin
            check("hash_in_hold", 512'(core_hash_in), 512'(hin_f));
            check("chunk_hold", core_chunk, chk_f);
        end
    endtask

    string msgs [8];

    function automatic string rep_a(input int n);
        string r = "";
        for (int i = 0; i < n; i++) r = {r, "a"};
        return r;
    endfunction

    task automatic send(input int id, input int gap_max, input int stray_at);
        string s = msgs[id];
        int n = s.len();
        int nw = n == 0 ? 1 : (n + 3) / 4;
        for (int k = 0; k < nw; k++) begin
            int t = 0;
            repeat (gap_max > 0 ? $urandom_range(gap_max, 0) : 0) tick();
            if (k == stray_at) begin
                stray = 1'b1;
                tick();
                stray = 1'b0;
            end
            for (int b = 0; b < 4; b++) s_data[31-8*b -: 8] = (4*k + b < n) ? s[4*k+b] : 8'ha5;
            s_nbytes = k == nw - 1 ? 3'(n - 4*k) : 3'd4;
            s_last   = k == nw - 1;
            s_valid  = 1'b1;
            while (!s_ready && t < 500) begin
                tick();
                t++;
            end
            check("handshake", 512'(s_ready), 512'(1));
            tick();
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_digest();
        int t = 0;
        while (!digest_valid && t < 1000) begin
            tick();
            t++;
        end
        check("digest_valid_seen", 512'(digest_valid), 512'(1));
    endtask

    typedef struct {
        int           id;
        int           gap;
        int           stray_at;
        int           nchunks;
        bit           chk_dig;
        logic [255:0] dig;
        logic [31:0]  w0;
        logic [31:0]  w15;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int f0, d0;
        msgs[0] = "abc";
        msgs[1] = "";
        msgs[2] = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        msgs[3] = "The quick brown fox jumps over the lazy dog";
        msgs[4] = "abcdefghbcdefghicdefghijdefghijkefghijklfghijklmghijklmnhijklmnoijklmnopjklmnopqklmnopqrlmnopqrsmnopqrstnopqrstu";
        msgs[5] = rep_a(55);
        msgs[6] = rep_a(64);
        msgs[7] = rep_a(60);
        tbl[0]  = '{0, 0, -1, 1, 1'b1, 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad, 32'h61626380, 32'h00000018};
        tbl[1]  = '{1, 0, -1, 1, 1'b1, 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855, 32'h80000000, 32'h00000000};
        tbl[2]  = '{2, 0, -1, 2, 1'b1, 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1, 32'h00000000, 32'h000001c0};
        tbl[3]  = '{3, 0, -1, 1, 1'b1, 256'hd7a8fbb3_07d78094_69ca9abc_b0082e4f_8d5651e4_6d3cdb76_2d02d0bf_37c9e592, 32'h54686520, 32'h00000158};
        tbl[4]  = '{4, 0, -1, 2, 1'b1, 256'hcf5b16a7_78af8380_036ce59e_7b049237_0b249b11_e8f07a51_afac4503_7afee9d1, 32'h696a6b6c, 32'h00000380};
        tbl[5]  = '{5, 0, -1, 1, 1'b0, 256'h0, 32'h61616161, 32'h000001b8};
        tbl[6]  = '{6, 0, -1, 2, 1'b0, 256'h0, 32'h80000000, 32'h00000200};
        tbl[7]  = '{7, 0, -1, 2, 1'b0, 256'h0, 32'h00000000, 32'h000001e0};
        tbl[8]  = '{2, 3, 5, 2, 1'b1, 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1, 32'h00000000, 32'h000001c0};
        tbl[9]  = '{4, 2, 20, 2, 1'b1, 256'hcf5b16a7_78af8380_036ce59e_7b049237_0b249b11_e8f07a51_afac4503_7afee9d1, 32'h696a6b6c, 32'h00000380};
        tbl[10] = '{0, 4, 0, 1, 1'b1, 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad, 32'h61626380, 32'h00000018};

        tick();
        tick();
        check("rst_s_ready", 512'(s_ready), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_flag", 512'(core_chunk_flag), 512'(0));
        check("rst_digest", 512'(digest), 512'(0));
        check("rst_digest_valid", 512'(digest_valid), 512'(0));
        check("rst_hash_in", 512'(core_hash_in), 512'(IV));
        rst = 1'b1;
        tick();
        check("ready_after_reset", 512'(s_ready), 512'(1));

        for (int v = 0; v < 11; v++) begin
            f0 = nflags;
            d0 = dv_cnt;
            send(tbl[v].id, tbl[v].gap, tbl[v].stray_at);
            check("busy_during", 512'(busy), 512'(1));
            wait_digest();
            check("busy_clear", 512'(busy), 512'(0));
            check("nchunks", 512'(nflags - f0), 512'(tbl[v].nchunks));
            check("last_w0", 512'(chk_f[511:480]), 512'(tbl[v].w0));
            check("last_w15", 512'(chk_f[31:0]), 512'(tbl[v].w15));
            if (tbl[v].chk_dig) check("digest", 512'(digest), 512'(tbl[v].dig));
            check("dv_pulses", 512'(dv_cnt - d0), 512'(1));
            tick();
            check("dv_one_cycle", 512'(digest_valid), 512'(0));
        end

        // Abort a two-chunk message while its first chunk is in flight, then hash "abc".
        f0 = nflags;
        d0 = dv_cnt;
        send(2, 0, -1);
        repeat (20) tick();
        rst = 1'b0;
        #1;
        check("abort_digest", 512'(digest), 512'(0));
        check("abort_s_ready", 512'(s_ready), 512'(0));
        check("abort_busy", 512'(busy), 512'(0));
        check("abort_hash_in", 512'(core_hash_in), 512'(IV));
        tick();
        tick();
        rst = 1'b1;
        send(0, 0, -1);
        wait_digest();
        check("abort_abc_digest", 512'(digest),
              512'(256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad));
        check("abort_abc_iv", 512'(hin_f), 512'(IV));
        check("abort_nchunks", 512'(nflags - f0), 512'(2));
        check("abort_dv_pulses", 512'(dv_cnt - d0), 512'(1));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
